// File: rtl/serial_paralelo_idle_if.sv
// serial_paralelo_idle_if: lane bus between the serial receiver and the idle-recirculation stage
//   data_in    serial bit stream, MSB first
//   data_out   last completed lane byte
//   byte_valid one-cycle strobe when data_out updates
//   valido     1 = data_out is real data (not COM/IDLE filler)
//   active     byte alignment locked
interface serial_paralelo_idle_if;
    logic       data_in;
    logic [7:0] data_out;
    logic       byte_valid;
    logic       valido;
    logic       active;
    modport master (output data_in, input data_out, byte_valid, valido, active);
    modport slave  (input data_in, output data_out, byte_valid, valido, active);
endinterface

// File: rtl/serial_paralelo_idle.sv
// serial_paralelo_idle: per-lane deserialiser that locks byte alignment on COM and tags filler bytes
//   clk32f  serial bit clock (8x byte rate)
//   reset   asynchronous, active-low
//   bus     serial_paralelo_idle_if.slave: data_in in; data_out, byte_valid, valido, active out
//   LOSS_OF_LOCK_EN (macro): drop lock after 4 consecutive 8'h00/8'hFF bytes
module serial_paralelo_idle #(
    parameter logic [7:0] COM_SYMBOL  = 8'hBC,
    parameter logic [7:0] IDLE_SYMBOL = 8'h7C,
    parameter int         LOCK_COUNT  = 4
) (
    input logic                   clk32f,
    input logic                   reset,
    serial_paralelo_idle_if.slave bus
);
    typedef enum logic [1:0] {SEARCH, ALIGN, ACTIVE} state_t;
    localparam logic [3:0] LC = 4'(LOCK_COUNT);
    state_t     r_state, w_state;
    logic [7:0] r_sr, r_data_out, w_data_out, w_nb;
    logic [2:0] r_bit_cnt, w_bit_cnt;
    logic [3:0] r_com_cnt, w_com_cnt;
    logic       r_byte_valid, w_byte_valid, r_valido, w_valido;
    logic       w_com, w_boundary;
`ifdef LOSS_OF_LOCK_EN
    logic [2:0] r_bad_cnt, w_bad_cnt;
    logic       w_bad;
    assign w_bad = w_nb == 8'h00 || w_nb == 8'hFF;
`endif
    // candidate byte includes the bit being sampled on this edge
    assign w_nb       = {r_sr[6:0], bus.data_in};
    assign w_com      = w_nb == COM_SYMBOL;
    assign w_boundary = r_bit_cnt == 3'd7;
    assign bus.data_out   = r_data_out;
    assign bus.byte_valid = r_byte_valid;
    assign bus.valido     = r_valido;
    assign bus.active     = r_state == ACTIVE;
    always_ff @(posedge clk32f or negedge reset) begin
        if (!reset) begin
            r_state      <= SEARCH;
            r_sr         <= 8'h00;
            r_bit_cnt    <= 3'd0;
            r_com_cnt    <= 4'd0;
            r_data_out   <= 8'h00;
            r_byte_valid <= 1'b0;
            r_valido     <= 1'b0;
`ifdef LOSS_OF_LOCK_EN
            r_bad_cnt    <= 3'd0;
`endif
        end else begin
            r_state      <= w_state;
            r_sr         <= w_nb;
            r_bit_cnt    <= w_bit_cnt;
            r_com_cnt    <= w_com_cnt;
            r_data_out   <= w_data_out;
            r_byte_valid <= w_byte_valid;
            r_valido     <= w_valido;
`ifdef LOSS_OF_LOCK_EN
            r_bad_cnt    <= w_bad_cnt;
`endif
        end
    end
    always_comb begin
        w_state      = r_state;
        w_bit_cnt    = r_bit_cnt + 3'd1;
        w_com_cnt    = r_com_cnt;
        w_data_out   = r_data_out;
        w_byte_valid = 1'b0;
        // valido only meaningful while locked; cleared on the edge after lock is lost
        w_valido     = r_state == ACTIVE ? r_valido : 1'b0;
`ifdef LOSS_OF_LOCK_EN
        w_bad_cnt    = r_bad_cnt;
`endif
        case (r_state)
            SEARCH: begin
                // any bit offset may match; a match defines the byte boundary
                w_bit_cnt = 3'd0;
                w_com_cnt = w_com ? 4'd1 : 4'd0;
                w_state   = !w_com ? SEARCH : (LC == 4'd1 ? ACTIVE : ALIGN);
            end
            ALIGN: if (w_boundary) begin
                w_com_cnt = w_com ? r_com_cnt + 4'd1 : 4'd0;
                w_state   = !w_com ? SEARCH : (r_com_cnt + 4'd1 == LC ? ACTIVE : ALIGN);
            end
            ACTIVE: if (w_boundary) begin
                w_data_out   = w_nb;
                w_byte_valid = 1'b1;
                w_valido     = !w_com && w_nb != IDLE_SYMBOL;
`ifdef LOSS_OF_LOCK_EN
                w_bad_cnt = w_bad ? r_bad_cnt + 3'd1 : 3'd0;
                // fourth stuck byte is still delivered, lock drops on the same edge
                if (w_bad && r_bad_cnt == 3'd3) begin
                    w_state   = SEARCH;
                    w_com_cnt = 4'd0;
                    w_bad_cnt = 3'd0;
                end
`endif
            end
            default: w_state = SEARCH;
        endcase
    end
endmodule

// File: tb/tb_serial_paralelo_idle.sv
// tb_serial_paralelo_idle: directed bench for the lane deserialiser and COM alignment lock
module tb_serial_paralelo_idle;
    logic clk32f = 1'b0;
    logic reset  = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    serial_paralelo_idle_if bus();
    serial_paralelo_idle dut (.clk32f(clk32f), .reset(reset), .bus(bus));

    always #5 clk32f = ~clk32f;

    task automatic send_bit(input logic b);
        bus.data_in = b;
        @(posedge clk32f);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        v = 16'hBCBC;
        reset = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            send_bit(v[i]);
            n_checks++;
            if ({bus.data_out, bus.byte_valid, bus.valido, bus.active} !== 11'h000) begin
                n_fail++;
                $display("FAIL reset_hold bit=%0d: data_out=%h bv=%b valido=%b active=%b, want all 0",
                         i, bus.data_out, bus.byte_valid, bus.valido, bus.active);
            end
        end
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send_bit(1'b0);
            n_checks++;
            if (bus.active !== 1'b0 || bus.byte_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_search bit=%0d: active=%b bv=%b, want 0 0", i, bus.active, bus.byte_valid);
            end
        end
    endtask

    task automatic test_align_offset();
        logic [7:0] b;
        repeat (3) send_bit(1'b0);
        b = 8'hBC;
        for (int k = 0; k < 4; k++)
            for (int i = 7; i >= 0; i--) begin
                send_bit(b[i]);
                n_checks++;
                if (bus.active !== (k == 3 && i == 0) || bus.byte_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL align_lock com=%0d bit=%0d: active=%b bv=%b, want %b 0",
                             k, i, bus.active, bus.byte_valid, (k == 3 && i == 0));
                end
            end
        b = 8'h5A;
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
            n_checks++;
            if (bus.byte_valid !== (i == 0)) begin
                n_fail++;
                $display("FAIL align_strobe bit=%0d: bv=%b, want %b", i, bus.byte_valid, (i == 0));
            end
        end
        n_checks++;
        if (bus.data_out !== 8'h5A || bus.valido !== 1'b1) begin
            n_fail++;
            $display("FAIL align_data: data_out=%h valido=%b, want 5a 1", bus.data_out, bus.valido);
        end
    endtask

    task automatic test_filler();
        logic [7:0] fb [3];
        logic       fv [3];
        logic [7:0] b;
        fb = '{8'hBC, 8'h7C, 8'h11};
        fv = '{1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            b = fb[k];
            for (int i = 7; i >= 0; i--) begin
                send_bit(b[i]);
                n_checks++;
                if (bus.byte_valid !== (i == 0)) begin
                    n_fail++;
                    $display("FAIL filler_strobe byte=%0d bit=%0d: bv=%b, want %b", k, i, bus.byte_valid, (i == 0));
                end
            end
            n_checks++;
            if (bus.data_out !== fb[k] || bus.valido !== fv[k] || bus.active !== 1'b1) begin
                n_fail++;
                $display("FAIL filler_class byte=%0d: data_out=%h valido=%b active=%b, want %h %b 1",
                         k, bus.data_out, bus.valido, bus.active, fb[k], fv[k]);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] b;
        b = 8'h42;
        for (int i = 7; i >= 5; i--) send_bit(b[i]);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.data_out, bus.byte_valid, bus.valido, bus.active} !== 11'h000) begin
            n_fail++;
            $display("FAIL midreset_async: data_out=%h bv=%b valido=%b active=%b, want all 0",
                     bus.data_out, bus.byte_valid, bus.valido, bus.active);
        end
        for (int i = 4; i >= 3; i--) begin
            send_bit(b[i]);
            n_checks++;
            if ({bus.data_out, bus.byte_valid, bus.valido, bus.active} !== 11'h000) begin
                n_fail++;
                $display("FAIL midreset_hold bit=%0d: data_out=%h active=%b, want 00 0", i, bus.data_out, bus.active);
            end
        end
        reset = 1'b1;
        b = 8'hBC;
        for (int k = 0; k < 4; k++)
            for (int i = 7; i >= 0; i--) begin
                send_bit(b[i]);
                n_checks++;
                if (bus.active !== (k == 3 && i == 0) || bus.byte_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL midreset_relock com=%0d bit=%0d: active=%b bv=%b, want %b 0",
                             k, i, bus.active, bus.byte_valid, (k == 3 && i == 0));
                end
            end
        b = 8'h33;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        n_checks++;
        if (bus.byte_valid !== 1'b1 || bus.data_out !== 8'h33 || bus.valido !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_data: bv=%b data_out=%h valido=%b, want 1 33 1",
                     bus.byte_valid, bus.data_out, bus.valido);
        end
    endtask

    task automatic test_loss_of_lock();
        logic [7:0] sb [4];
        logic [7:0] b;
        logic       exp_act;
        sb = '{8'hFF, 8'h00, 8'hFF, 8'h00};
        for (int k = 0; k < 4; k++) begin
            b = sb[k];
            for (int i = 7; i >= 0; i--) send_bit(b[i]);
`ifdef LOSS_OF_LOCK_EN
            exp_act = (k != 3);
`else
            exp_act = 1'b1;
`endif
            n_checks++;
            if (bus.byte_valid !== 1'b1 || bus.data_out !== sb[k] || bus.valido !== 1'b1 || bus.active !== exp_act) begin
                n_fail++;
                $display("FAIL stuck_bytes byte=%0d: bv=%b data_out=%h valido=%b active=%b, want 1 %h 1 %b",
                         k, bus.byte_valid, bus.data_out, bus.valido, bus.active, sb[k], exp_act);
            end
        end
`ifdef LOSS_OF_LOCK_EN
        send_bit(1'b0);
        n_checks++;
        if (bus.valido !== 1'b0 || bus.data_out !== 8'h00 || bus.active !== 1'b0 || bus.byte_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lol_after: valido=%b data_out=%h active=%b bv=%b, want 0 00 0 0",
                     bus.valido, bus.data_out, bus.active, bus.byte_valid);
        end
        b = 8'hBC;
        for (int k = 0; k < 4; k++)
            for (int i = 7; i >= 0; i--) begin
                send_bit(b[i]);
                n_checks++;
                if (bus.active !== (k == 3 && i == 0) || bus.byte_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lol_relock com=%0d bit=%0d: active=%b bv=%b, want %b 0",
                             k, i, bus.active, bus.byte_valid, (k == 3 && i == 0));
                end
            end
`endif
        sb = '{8'hFF, 8'hFF, 8'h12, 8'hFF};
        for (int k = 0; k < 4; k++) begin
            b = sb[k];
            for (int i = 7; i >= 0; i--) send_bit(b[i]);
            n_checks++;
            if (bus.byte_valid !== 1'b1 || bus.data_out !== sb[k] || bus.valido !== 1'b1 || bus.active !== 1'b1) begin
                n_fail++;
                $display("FAIL stuck_broken byte=%0d: bv=%b data_out=%h valido=%b active=%b, want 1 %h 1 1",
                         k, bus.byte_valid, bus.data_out, bus.valido, bus.active, sb[k]);
            end
        end
    endtask

    task automatic test_broken_lock();
        logic [7:0] pre [3];
        logic [7:0] b;
        pre = '{8'hBC, 8'hBC, 8'h3C};
        reset = 1'b0;
        send_bit(1'b0);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            b = pre[k];
            for (int i = 7; i >= 0; i--) begin
                send_bit(b[i]);
                n_checks++;
                if (bus.active !== 1'b0 || bus.byte_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL broken_pre byte=%0d bit=%0d: active=%b bv=%b, want 0 0",
                             k, i, bus.active, bus.byte_valid);
                end
            end
        end
        b = 8'hBC;
        for (int k = 0; k < 4; k++)
            for (int i = 7; i >= 0; i--) begin
                send_bit(b[i]);
                n_checks++;
                if (bus.active !== (k == 3 && i == 0) || bus.byte_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL broken_relock com=%0d bit=%0d: active=%b bv=%b, want %b 0",
                             k, i, bus.active, bus.byte_valid, (k == 3 && i == 0));
                end
            end
    endtask

    initial begin
        bus.data_in = 1'b0;
        test_reset();
        test_align_offset();
        test_filler();
        test_mid_reset();
        test_loss_of_lock();
        test_broken_lock();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
